tour_cmd_sequencer: RTL and testbench
=====================================

// Module: tour_cmd_sequencer
// PURPOSE
//  Host-side stage directly upstream of RemoteComm: buffers a list of 16-bit Knight commands
//  (CAL, move 0x4xxx, move+fanfare 0x5xxx) and plays them out one at a time over the
//  snd_cmd/cmd_snt handshake, waiting for the 0xA5 positive ack on resp_rdy before the next.
//  Reports completion, command count and errors (NAK/timeout). Drives full tours unattended.
// PARAMETERS
//  DEPTH     8           FIFO entries (power of 2, >=2)
//  TMO_CLKS  30_000_000  max clocks from cmd_snt to resp_rdy before timeout
//  MAX_RETRY 2           resends of a timed-out command (used only with SEQ_RETRY_EN)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  wr_en      in   1   push wr_cmd into FIFO
//  wr_cmd     in   16  command to enqueue
//  start      in   1   begin playback (pulse; ignored while busy)
//  abort      in   1   stop playback, flush FIFO
//  cmd        out  16  command to RemoteComm
//  snd_cmd    out  1   1-clk send strobe to RemoteComm
//  cmd_snt    in   1   RemoteComm finished transmitting cmd
//  resp_rdy   in   1   response byte valid (1 clk)
//  resp       in   8   response byte
//  busy       out  1   playback in progress
//  done       out  1   1-clk pulse, all queued commands acked
//  err        out  1   sticky error, cleared by start/abort
//  err_code   out  2   0 none, 1 NAK (resp!=0xA5), 2 timeout, 3 overflow write
//  fifo_cnt   out  $clog2(DEPTH)+1  entries queued
//  acked_cnt  out  8   commands acked since last start (saturates 255)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE.
//  States: IDLE, SEND, WAIT_SNT, WAIT_RESP, ERR.
//  IDLE: start & fifo_cnt>0 -> SEND, clear err/acked_cnt; start & empty -> done pulse next clk.
//  SEND: cmd<=FIFO head, snd_cmd=1 exactly one clk -> WAIT_SNT. snd_cmd is 1 clk after start.
//  WAIT_SNT: on cmd_snt -> WAIT_RESP, timeout counter cleared.
//  WAIT_RESP: resp_rdy & resp==8'hA5 -> pop head, acked_cnt++; FIFO now empty -> IDLE, done=1;
//   else -> SEND. resp_rdy & resp!=8'hA5 -> ERR, err_code=1, head kept.
//   Counter reaches TMO_CLKS-1 with no resp_rdy -> ERR, err_code=2.
//  ERR: busy=0, err=1; wait for start (resume from head, same cmd resent) or abort.
//  cmd holds its value between SEND strobes; changes only in SEND.
//  FIFO: writes accepted in any state, incl. during playback (appended to tour).
//   wr_en while full: write dropped, err=1, err_code=3 (does not stop playback).
//   wr_en and pop same clk: both occur, fifo_cnt unchanged. Pointers wrap mod DEPTH.
//  abort: any state -> IDLE next clk, FIFO flushed, snd_cmd=0, err cleared; late resp_rdy ignored.
//  abort and start same clk: abort wins. start ignored in SEND/WAIT_*.
//  resp_rdy outside WAIT_RESP ignored. acked_cnt saturates at 8'hFF.
// CONFIGURATION
//  SEQ_RETRY_EN defined: timeout re-enters SEND with same head cmd up to MAX_RETRY times
//   (retry count reset per command on ack); ERR/err_code=2 only after MAX_RETRY+1 timeouts.
//   NAK never retried.
//  SEQ_RETRY_EN undefined: first timeout -> ERR; MAX_RETRY unused, no retry counter built.
// STRUCTURE
//  tour_pkg: ACK_RESP=8'hA5, opcode constants (CAL_GYRO, MOVE=4'h4, MOVE_FAN=4'h5),
//   heading codes, seq_state_t enum, err_code_t enum.
//  One sub-module: tour_cmd_fifo (DEPTH x 16, push/pop/full/empty/cnt, flush) holds storage;
//   sequencer FSM, timeout counter, retry counter, stats in top.
// TESTING
//  1 push 16'h2000,16'h4002,16'h5BF1; start; ack each with 8'hA5 -> three snd_cmd in order,
//    done pulse after 3rd ack, acked_cnt=3, fifo_cnt=0, err=0.
//  2 push 16'h47F1; start; resp=8'h5A -> err=1, err_code=1, fifo_cnt=1; start; ack -> resend
//    16'h47F1, done, err=0.
//  3 TMO_CLKS=1000, no resp after cmd_snt -> err_code=2 at clk 1000 (retry off); with
//    SEQ_RETRY_EN, MAX_RETRY=2 -> 3 snd_cmd of same cmd then err_code=2.
//  4 push DEPTH+1 cmds idle -> fifo_cnt=DEPTH, err_code=3; push during playback same clk
//    as ack pop -> fifo_cnt unchanged, appended cmd sent last.
//  5 abort in WAIT_RESP then resp_rdy=8'hA5 -> IDLE, fifo_cnt=0, acked_cnt unchanged, no done.
//  6 rst_n low mid WAIT_SNT -> all outputs 0 immediately; start on empty FIFO -> done, no snd_cmd.

Source files
------------

// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared constants and types for the tour command sequencer
// Purpose: Knight command opcodes, heading codes, the positive-ack byte,
//          the sequencer state enum and the error-code enum.
// Ports:   none (package).
package tour_pkg;

  localparam logic [7:0]  ACK_RESP = 8'hA5;

  localparam logic [15:0] CAL_GYRO = 16'h2000;
  localparam logic [3:0]  MOVE     = 4'h4;
  localparam logic [3:0]  MOVE_FAN = 4'h5;

  localparam logic [7:0]  HDG_NORTH = 8'h00;
  localparam logic [7:0]  HDG_WEST  = 8'h3F;
  localparam logic [7:0]  HDG_SOUTH = 8'h7F;
  localparam logic [7:0]  HDG_EAST  = 8'hBF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SNT,
    S_WAIT_RESP,
    S_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_NAK  = 2'd1,
    ERR_TMO  = 2'd2,
    ERR_OVF  = 2'd3
  } err_code_t;

endpackage

// File: rtl/tour_cmd_fifo.sv
// rtl/tour_cmd_fifo.sv - DEPTH x 16 command FIFO with flush and head lookahead
// Purpose: holds queued Knight commands; exposes the head entry and the entry
//          behind it so the sequencer can load the next command on the same
//          clock it pops the current one.
// Ports:   clk_i, rst_n_i (async active-low), flush_i (empties FIFO),
//          push_i/data_i (enqueue), pop_i (dequeue head),
//          head_o (current head), next_o (entry after head),
//          full_o, empty_o, cnt_o (entries queued).
module tour_cmd_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [15:0]   data_i,
  input  logic          pop_i,
  output logic [15:0]   head_o,
  output logic [15:0]   next_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o
);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A pop on the same clock frees a slot, so a push into a full FIFO still lands.
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + AW'(1)];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop) cnt_q <= cnt_q + CW'(1);
      if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// rtl/tour_cmd_sequencer.sv - plays a queued Knight tour out to RemoteComm one ack at a time
// Purpose: buffers 16-bit commands, sends each with a 1-clk snd_cmd strobe,
//          waits for cmd_snt then the 0xA5 ack, and reports done/err/counts.
//          Build option SEQ_RETRY_EN: a timed-out command is resent up to
//          MAX_RETRY times before the error is raised.
// Ports:   clk_i, rst_n_i (async active-low); wr_en_i/wr_cmd_i (enqueue);
//          start_i, abort_i (control); cmd_o/snd_cmd_o, cmd_snt_i,
//          resp_rdy_i/resp_i (RemoteComm handshake); busy_o, done_o, err_o,
//          err_code_o, fifo_cnt_o, acked_cnt_o (status).
module tour_cmd_sequencer
  import tour_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int TMO_CLKS  = 30_000_000,
  parameter  int MAX_RETRY = 2,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [15:0]   wr_cmd_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [15:0]   cmd_o,
  output logic          snd_cmd_o,
  input  logic          cmd_snt_i,
  input  logic          resp_rdy_i,
  input  logic [7:0]    resp_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [CW-1:0] fifo_cnt_o,
  output logic [7:0]    acked_cnt_o
);

  localparam int TW = $clog2(TMO_CLKS);

  seq_state_t    state_q;
  err_code_t     err_code_q;
  logic [15:0]   cmd_q;
  logic          snd_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    acked_q;
  logic [TW-1:0] tmo_q;

  logic [15:0]   fifo_head;
  logic [15:0]   fifo_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;

  logic          ack_d;
  logic          pop_d;
  logic          ovf_d;
  logic          more_d;
  logic [15:0]   next_cmd_d;
  logic          tmo_hit_d;

`ifdef SEQ_RETRY_EN
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q;
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
`endif

  assign ack_d     = resp_rdy_i & (resp_i == ACK_RESP);
  assign pop_d     = (state_q == S_WAIT_RESP) & ack_d & ~abort_i;
  assign ovf_d     = wr_en_i & fifo_full & ~pop_d & ~abort_i;
  assign tmo_hit_d = (tmo_q == TW'(TMO_CLKS - 1));
  // After popping the head, the next command is the entry behind it, or the
  // command being written this very clock when the head was the last entry.
  assign more_d     = (fifo_cnt > CW'(1)) | wr_en_i;
  assign next_cmd_d = (fifo_cnt > CW'(1)) ? fifo_next : wr_cmd_i;

  tour_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (abort_i),
    .push_i  (wr_en_i),
    .data_i  (wr_cmd_i),
    .pop_i   (pop_d),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  // snd_q is raised on the transition into S_SEND, so the strobe is high for
  // exactly the one clock spent in S_SEND and cmd_q is already valid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      err_code_q <= ERR_NONE;
      cmd_q      <= '0;
      snd_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      acked_q    <= '0;
      tmo_q      <= '0;
`ifdef SEQ_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      snd_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort_i) begin
        state_q    <= S_IDLE;
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
        tmo_q      <= '0;
`ifdef SEQ_RETRY_EN
        retry_q    <= '0;
`endif
      end else begin
        case (state_q)
          S_IDLE, S_ERR: begin
            if (start_i) begin
              err_q      <= 1'b0;
              err_code_q <= ERR_NONE;
              acked_q    <= '0;
`ifdef SEQ_RETRY_EN
              retry_q    <= '0;
`endif
              if (fifo_empty) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_SEND;
                cmd_q   <= fifo_head;
                snd_q   <= 1'b1;
              end
            end
          end
          S_SEND: state_q <= S_WAIT_SNT;
          S_WAIT_SNT: begin
            if (cmd_snt_i) begin
              state_q <= S_WAIT_RESP;
              tmo_q   <= '0;
            end
          end
          S_WAIT_RESP: begin
            if (resp_rdy_i) begin
              if (ack_d) begin
                if (acked_q != 8'hFF) acked_q <= acked_q + 8'd1;
`ifdef SEQ_RETRY_EN
                retry_q <= '0;
`endif
                if (more_d) begin
                  state_q <= S_SEND;
                  cmd_q   <= next_cmd_d;
                  snd_q   <= 1'b1;
                end else begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
                end
              end else begin
                state_q    <= S_ERR;
                err_q      <= 1'b1;
                err_code_q <= ERR_NAK;
              end
            end else if (tmo_hit_d) begin
`ifdef SEQ_RETRY_EN
              if (retry_q < RW'(MAX_RETRY)) begin
                retry_q <= retry_q + RW'(1);
                state_q <= S_SEND;
                cmd_q   <= fifo_head;
                snd_q   <= 1'b1;
              end else begin
                state_q    <= S_ERR;
                err_q      <= 1'b1;
                err_code_q <= ERR_TMO;
              end
`else
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              err_code_q <= ERR_TMO;
`endif
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
      // Overflow is flagged without disturbing playback.
      if (ovf_d) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_OVF;
      end
    end
  end

  assign cmd_o       = cmd_q;
  assign snd_cmd_o   = snd_q;
  assign busy_o      = (state_q == S_SEND) | (state_q == S_WAIT_SNT) | (state_q == S_WAIT_RESP);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign fifo_cnt_o  = fifo_cnt;
  assign acked_cnt_o = acked_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb/tb_tour_cmd_sequencer.sv - self-checking bench for tour_cmd_sequencer
module tb_tour_cmd_sequencer;
  import tour_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 1000;
  localparam int MAXR  = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef SEQ_RETRY_EN
  localparam int TRIES = MAXR + 1;
`else
  localparam int TRIES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [15:0]   wr_cmd = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cmd_snt = 1'b0;
  logic          resp_rdy = 1'b0;
  logic [7:0]    resp = '0;
  logic [15:0]   cmd;
  logic          snd_cmd, busy, done, err;
  logic [1:0]    err_code;
  logic [CW-1:0] fifo_cnt;
  logic [7:0]    acked_cnt;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: the tour as a queue plus the status it should report.
  logic [15:0] exp_q[$];
  int          exp_acked = 0;
  logic        exp_err = 1'b0;
  logic [1:0]  exp_code = 2'd0;

  always #5 clk = ~clk;

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TMO_CLKS(TMO), .MAX_RETRY(MAXR)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .wr_en_i     (wr_en),
    .wr_cmd_i    (wr_cmd),
    .start_i     (start),
    .abort_i     (abort),
    .cmd_o       (cmd),
    .snd_cmd_o   (snd_cmd),
    .cmd_snt_i   (cmd_snt),
    .resp_rdy_i  (resp_rdy),
    .resp_i      (resp),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_code_o  (err_code),
    .fifo_cnt_o  (fifo_cnt),
    .acked_cnt_o (acked_cnt)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_cnt"},   32'(fifo_cnt),  32'(exp_q.size()));
    chk({tag, "_acked"}, 32'(acked_cnt), 32'(exp_acked));
    chk({tag, "_err"},   32'(err),       32'(exp_err));
    chk({tag, "_code"},  32'(err_code),  32'(exp_code));
  endtask

  function automatic logic [15:0] rand_cmd();
    case ($urandom_range(0, 2))
      0:       return CAL_GYRO;
      1:       return {MOVE, 12'($urandom)};
      default: return {MOVE_FAN, 12'($urandom)};
    endcase
  endfunction

  task automatic push(input logic [15:0] c);
    wr_en = 1'b1; wr_cmd = c;
    tick();
    wr_en = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(c);
    else begin exp_err = 1'b1; exp_code = 2'd3; end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_err = 1'b0; exp_code = 2'd0; exp_acked = 0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete(); exp_err = 1'b0; exp_code = 2'd0;
  endtask

  task automatic wait_snd(output logic [15:0] c);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (snd_cmd) ok = 1'b1;
      else tick();
    end
    if (!ok) chk("snd_wait_expired", 32'(snd_cmd), 32'(1));
    c = cmd;
  endtask

  // One command round trip: strobe, cmd_snt, response r; optionally a new
  // command is written on the very clock of the response.
  task automatic serve_one(input logic [7:0] r, input bit push_new, input logic [15:0] newc);
    logic [15:0] c;
    wait_snd(c);
    chk("cmd_order", 32'(c), 32'(exp_q[0]));
    tick();
    chk("snd_1clk", 32'(snd_cmd), 32'(0));
    repeat ($urandom_range(0, 3)) tick();
    if ($urandom_range(0, 3) == 0) begin
      resp_rdy = 1'b1; resp = ACK_RESP;
      tick();
      resp_rdy = 1'b0;
      chk("early_resp_ignored", 32'(fifo_cnt), 32'(exp_q.size()));
    end
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    chk("busy_wait", 32'(busy), 32'(1));
    repeat ($urandom_range(0, 5)) tick();
    resp_rdy = 1'b1; resp = r;
    if (push_new) begin wr_en = 1'b1; wr_cmd = newc; end
    tick();
    resp_rdy = 1'b0; wr_en = 1'b0;
    if (r == ACK_RESP) begin
      void'(exp_q.pop_front());
      if (exp_acked < 255) exp_acked++;
    end else begin
      exp_err = 1'b1; exp_code = 2'd1;
    end
    if (push_new) exp_q.push_back(newc);
    chk_status("resp");
    chk("done", 32'(done), 32'(r == ACK_RESP && exp_q.size() == 0));
    chk("busy_after", 32'(busy), 32'(r == ACK_RESP && exp_q.size() != 0));
  endtask

  task automatic run_tour(input int nak_pct, input int push_pct);
    int guard;
    bit nak;
    bit pw;
    logic [7:0] r;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      guard++;
      nak = ($urandom_range(0, 99) < nak_pct);
      pw  = ($urandom_range(0, 99) < push_pct) && (exp_q.size() < DEPTH);
      r   = nak ? (ACK_RESP ^ 8'($urandom_range(1, 255))) : ACK_RESP;
      serve_one(r, pw, rand_cmd());
      if (nak) begin
        do_start();
        chk("resume_snd", 32'(snd_cmd), 32'(1));
      end else if (exp_q.size() == 0) begin
        tick();
        chk("done_pulse_end", 32'(done), 32'(0));
      end
    end
    chk_status("tour_end");
  endtask

  initial begin
    logic [15:0] c;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd", 32'(cmd), 32'(0));
    chk("rst_snd", 32'(snd_cmd), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk_status("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Three-command tour, all acked
    push(CAL_GYRO);
    push({MOVE, 12'h002});
    push({MOVE_FAN, 12'hBF1});
    do_start();
    chk("t1_snd_lat", 32'(snd_cmd), 32'(1));
    for (int i = 0; i < 3; i++) serve_one(ACK_RESP, 1'b0, 16'h0);
    chk("t1_acked", 32'(acked_cnt), 32'(3));
    tick();
    chk("t1_done_1clk", 32'(done), 32'(0));

    // NAK then resume resends the same command
    push(16'h47F1);
    do_start();
    serve_one(8'h5A, 1'b0, 16'h0);
    chk("t2_busy", 32'(busy), 32'(0));
    do_start();
    chk("t2_resend_snd", 32'(snd_cmd), 32'(1));
    serve_one(ACK_RESP, 1'b0, 16'h0);

    // Timeout: counter limit TMO-1 after cmd_snt
    push({MOVE, 12'h002});
    do_start();
    for (int a = 0; a < TRIES; a++) begin
      wait_snd(c);
      chk("tmo_cmd", 32'(c), 32'({MOVE, 12'h002}));
      tick();
      cmd_snt = 1'b1;
      tick();
      cmd_snt = 1'b0;
      repeat (TMO - 1) tick();
      chk("tmo_not_yet", 32'(err), 32'(0));
      chk("tmo_no_resend", 32'(snd_cmd), 32'(0));
      tick();
      if (a == TRIES - 1) begin
        exp_err = 1'b1; exp_code = 2'd2;
        chk_status("tmo");
        chk("tmo_busy", 32'(busy), 32'(0));
      end else begin
        chk("tmo_retry_snd", 32'(snd_cmd), 32'(1));
      end
    end
    do_abort();
    chk_status("tmo_abort");

    // Overflow while idle, then push on the same clock as an ack pop
    for (int i = 0; i <= DEPTH; i++) push(rand_cmd());
    chk_status("ovf");
    do_start();
    chk("ovf_snd_lat", 32'(snd_cmd), 32'(1));
    serve_one(ACK_RESP, 1'b1, 16'h4ABC);
    chk("ovf_cnt_same", 32'(fifo_cnt), 32'(DEPTH));
    run_tour(0, 0);

    // Abort in WAIT_RESP, late ack ignored
    push(rand_cmd()); push(rand_cmd()); push(rand_cmd());
    do_start();
    serve_one(ACK_RESP, 1'b0, 16'h0);
    wait_snd(c);
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    do_abort();
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    resp_rdy = 1'b1; resp = ACK_RESP;
    tick();
    resp_rdy = 1'b0;
    chk_status("late_resp");
    chk("late_done", 32'(done), 32'(0));
    chk("late_snd", 32'(snd_cmd), 32'(0));

    // Randomized tours with NAKs and appended commands
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push(rand_cmd());
      do_start();
      chk("rnd_snd_lat", 32'(snd_cmd), 32'(1));
      run_tour(20, 30);
    end

    // Reset mid WAIT_SNT, then start on empty FIFO
    push({MOVE_FAN, 12'hBF1});
    do_start();
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete(); exp_acked = 0; exp_err = 1'b0; exp_code = 2'd0;
    chk("rst2_cmd", 32'(cmd), 32'(0));
    chk("rst2_busy", 32'(busy), 32'(0));
    chk("rst2_snd", 32'(snd_cmd), 32'(0));
    chk_status("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start_done", 32'(done), 32'(1));
    chk("empty_start_snd", 32'(snd_cmd), 32'(0));
    chk("empty_start_busy", 32'(busy), 32'(0));
    tick();
    chk("empty_done_1clk", 32'(done), 32'(0));
    chk("empty_no_snd", 32'(snd_cmd), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
